// File: rtl/booth_mac_accum_pkg.sv
// Shared types for the Booth MAC accumulator: FSM state encoding and term counter width.
package booth_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int TERM_W = 8;

endpackage

// File: rtl/booth_mac_accum_if.sv
// Product/result bundle between the Booth multiplier, the accumulator and its consumer.
interface booth_mac_accum_if #(
  parameter int WIDTH = 64,
  parameter int GUARD = 4
);
  import booth_pkg::*;

  logic signed [2*WIDTH-1:0]       prod_in;
  logic                            finish_in;
  logic                            clear;
  logic                            acc_ready;
  logic signed [2*WIDTH+GUARD-1:0] acc_out;
  logic                            acc_valid;
  logic [TERM_W-1:0]               term_count;
  logic                            overflow;
  logic                            overrun;

  modport master (
    output prod_in, finish_in, clear, acc_ready,
    input  acc_out, acc_valid, term_count, overflow, overrun
  );

  modport slave (
    input  prod_in, finish_in, clear, acc_ready,
    output acc_out, acc_valid, term_count, overflow, overrun
  );

endinterface

// File: rtl/booth_mac_accum_finish_edge.sv
// Rising-edge detector for the multiplier Finish level; history resets high so a level
// already asserted when reset releases is not taken as a new product.
module booth_finish_edge (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic rise_out
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= level_in;
  end

  assign rise_out = level_in & ~prev_q;

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates NUM_TERMS signed Booth products into one sum and hands it off via valid/ready.
// Build option BOOTH_ACC_SATURATE_EN: clamp on overflow instead of wrapping.
module booth_mac_accum
  import booth_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int NUM_TERMS = 4,
  parameter int GUARD     = 4
) (
  input logic              clk,
  input logic              reset,
  booth_mac_accum_if.slave bus
);

  localparam int AW = 2*WIDTH + GUARD;
  localparam logic [TERM_W-1:0] TERMS = TERM_W'(NUM_TERMS);

  typedef logic signed [AW-1:0] acc_t;
  typedef logic signed [AW:0]   sum_t;

  state_t            state_q, state_d;
  acc_t              acc_q, acc_d;
  logic [TERM_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              ovr_q, ovr_d;
  logic              rise;
  sum_t              sum_full;
  logic              add_ovf;
  acc_t              add_res;
  logic [TERM_W-1:0] cnt_inc;

  booth_finish_edge u_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (bus.finish_in),
    .rise_out (rise)
  );

  // One extra bit exposes the true signed result; overflow when the top two bits disagree.
  always_comb begin
    sum_full = sum_t'(acc_q) + sum_t'(bus.prod_in);
    add_ovf  = sum_full[AW] ^ sum_full[AW-1];
`ifdef BOOTH_ACC_SATURATE_EN
    if (add_ovf)
      add_res = sum_full[AW] ? acc_t'({1'b1, {(AW-1){1'b0}}})
                             : acc_t'({1'b0, {(AW-1){1'b1}}});
    else
      add_res = sum_full[AW-1:0];
`else
    add_res = sum_full[AW-1:0];
`endif
    cnt_inc = cnt_q + TERM_W'(1);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ovr_d   = ovr_q;
    if (bus.clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (rise) begin
            acc_d = add_res;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_ovf;
            if (cnt_inc == TERMS) state_d = DONE;
          end
        end
        DONE: begin
          if (bus.acc_ready) begin
            // A product arriving with the handshake seeds the next sum directly.
            ovf_d = 1'b0;
            if (rise) begin
              acc_d   = acc_t'(bus.prod_in);
              cnt_d   = TERM_W'(1);
              state_d = (TERMS == TERM_W'(1)) ? DONE : ACCUM;
            end else begin
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ACCUM;
            end
          end else if (rise) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.acc_out    = acc_q;
  assign bus.acc_valid  = (state_q == DONE);
  assign bus.term_count = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Scoreboard bench: two accumulators (GUARD=2/N=4 and GUARD=0/N=2) share one stimulus stream
// and are checked against a product-list reference model.
module tb_booth_mac_accum;

  localparam int W   = 4;
  localparam int N0  = 4;
  localparam int G0  = 2;
  localparam int N1  = 2;
  localparam int G1  = 0;

  typedef struct {
    longint sum;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_mac_accum_if #(.WIDTH(W), .GUARD(G0)) bus0 ();
  booth_mac_accum_if #(.WIDTH(W), .GUARD(G1)) bus1 ();

  booth_mac_accum #(.WIDTH(W), .NUM_TERMS(N0), .GUARD(G0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0)
  );
  booth_mac_accum #(.WIDTH(W), .NUM_TERMS(N1), .GUARD(G1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  exp_t   expq0[$];
  exp_t   expq1[$];
  longint prods[2][256];
  int     mcnt[2];
  bit     movr[2];
  bit     mprev;
  bit     seen[2];
  int     nterms[2] = '{N0, N1};
  int     aws[2]    = '{2*W+G0, 2*W+G1};

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  // Reference: replay the product list with plain integer arithmetic in the accumulator range.
  function automatic exp_t fold(input int k);
    exp_t   r;
    longint lo   = -(longint'(1) << (aws[k] - 1));
    longint hi   = -lo - 1;
    longint span = longint'(1) << aws[k];
    longint t;
    r.sum = 0;
    r.ovf = 1'b0;
    for (int i = 0; i < mcnt[k]; i++) begin
      t = r.sum + prods[k][i];
      if (t > hi || t < lo) begin
        r.ovf = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
        t = (t > hi) ? hi : lo;
`else
        t = (t > hi) ? t - span : t + span;
`endif
      end
      r.sum = t;
    end
    return r;
  endfunction

  task automatic capture(input int k, input longint p);
    prods[k][mcnt[k]] = p;
    mcnt[k]++;
    if (mcnt[k] == nterms[k]) begin
      if (k == 0) expq0.push_back(fold(k));
      else        expq1.push_back(fold(k));
    end
  endtask

  task automatic model_edge(input bit f, input longint p, input bit c, input bit r, input bit rs);
    bit rise;
    rise  = f && !mprev;
    mprev = f;
    if (!rs) begin
      mprev = 1'b1;
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0;
        movr[k] = 1'b0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (c) begin
        mcnt[k] = 0;
        movr[k] = 1'b0;
      end else if (mcnt[k] == nterms[k]) begin
        if (r) begin
          mcnt[k] = 0;
          if (rise) capture(k, p);
        end else if (rise) begin
          movr[k] = 1'b1;
        end
      end else if (rise) begin
        capture(k, p);
      end
    end
  endtask

  task automatic step(input bit f, input longint p, input bit c, input bit r);
    bus0.finish_in = f;        bus1.finish_in = f;
    bus0.prod_in   = 8'(p);    bus1.prod_in   = 8'(p);
    bus0.clear     = c;        bus1.clear     = c;
    bus0.acc_ready = r;        bus1.acc_ready = r;
    @(posedge clk);
    model_edge(f, p, c, r, rst);
    #1;
  endtask

  task automatic pulse(input longint p, input bit r);
    step(1'b1, p, 1'b0, r);
    step(1'b0, p, 1'b0, r);
  endtask

  task automatic mon(input int k, input bit v, input longint acc, input bit ovf,
                     input longint tc, input bit ovr, input bit rdy, input bit clr);
    exp_t e;
    bit   have;
    chk($sformatf("d%0d_valid", k), longint'(v), longint'(mcnt[k] == nterms[k]));
    chk($sformatf("d%0d_count", k), tc, longint'(mcnt[k]));
    chk($sformatf("d%0d_overrun", k), longint'(ovr), longint'(movr[k]));
    if (v && !seen[k]) begin
      if (k == 0) begin
        have = (expq0.size() != 0);
        if (have) e = expq0.pop_front();
      end else begin
        have = (expq1.size() != 0);
        if (have) e = expq1.pop_front();
      end
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL d%0d_unexpected_sum actual=%0d expected=none", k, acc);
      end else begin
        chk($sformatf("d%0d_sum", k), acc, e.sum);
        chk($sformatf("d%0d_ovf", k), longint'(ovf), longint'(e.ovf));
      end
      seen[k] = 1'b1;
    end
    if (!rst || clr || (v && rdy)) seen[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    mon(0, bus0.acc_valid, longint'(bus0.acc_out), bus0.overflow,
        longint'(bus0.term_count), bus0.overrun, bus0.acc_ready, bus0.clear);
    mon(1, bus1.acc_valid, longint'(bus1.acc_out), bus1.overflow,
        longint'(bus1.term_count), bus1.overrun, bus1.acc_ready, bus1.clear);
  end

  initial begin
    logic signed [7:0] pb;
    bit f, c, r;
    seen = '{1'b0, 1'b0};
    rst  = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("reset_acc", longint'(bus0.acc_out), 0);
    chk("reset_valid", longint'(bus0.acc_valid), 0);
    rst = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) pulse(18, 1'b0);
    chk("four_18_sum", longint'(bus0.acc_out), 72);
    chk("four_18_count", longint'(bus0.term_count), 4);
    chk("four_18_valid", longint'(bus0.acc_valid), 1);
    step(1'b0, 0, 1'b0, 1'b1);

    pulse(-56, 1'b0); pulse(64, 1'b0); pulse(-8, 1'b0); pulse(8, 1'b0);
    repeat (5) step(1'b0, 0, 1'b0, 1'b0);
    chk("hold_sum", longint'(bus0.acc_out), 8);
    chk("hold_valid", longint'(bus0.acc_valid), 1);
    pulse(3, 1'b0);
    chk("overrun_set", longint'(bus0.overrun), 1);
    chk("overrun_sum", longint'(bus0.acc_out), 8);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);

    repeat (10) step(1'b1, 7, 1'b0, 1'b0);
    chk("level_once", longint'(bus0.term_count), 1);
    rst = 1'b0;
    step(1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) step(1'b1, 7, 1'b0, 1'b0);
    chk("high_at_release", longint'(bus0.term_count), 0);
    step(1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) pulse(1, 1'b0);
    step(1'b1, 5, 1'b0, 1'b1);
    chk("hs_edge_valid", longint'(bus0.acc_valid), 0);
    chk("hs_edge_sum", longint'(bus0.acc_out), 5);
    chk("hs_edge_count", longint'(bus0.term_count), 1);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    pulse(64, 1'b0); pulse(64, 1'b0);
`ifdef BOOTH_ACC_SATURATE_EN
    chk("g0_sat_sum", longint'(bus1.acc_out), 127);
`else
    chk("g0_wrap_sum", longint'(bus1.acc_out), -128);
`endif
    chk("g0_overflow", longint'(bus1.overflow), 1);
    step(1'b0, 0, 1'b1, 1'b0);

    pulse(1, 1'b0); pulse(2, 1'b0);
    step(1'b1, 3, 1'b1, 1'b0);
    chk("clear_sum", longint'(bus0.acc_out), 0);
    chk("clear_count", longint'(bus0.term_count), 0);
    chk("clear_overflow", longint'(bus0.overflow), 0);
    chk("clear_overrun", longint'(bus0.overrun), 0);
    step(1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      pb  = 8'($urandom);
      f   = 1'($urandom_range(0, 1));
      c   = ($urandom_range(0, 39) == 0);
      r   = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) != 0);
      step(f, longint'(pb), c, r);
    end

    rst = 1'b1;
    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
    chk("d0_queue_drained", longint'(expq0.size()), 0);
    chk("d1_queue_drained", longint'(expq1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mac_accum.md
BOOTH_MAC_ACCUM -- requirements
Module: booth_mac_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand width of the upstream Booth multiplier.
REQ-002 SHALL have parameter NUM_TERMS, default 4: number of products per accumulated sum (1..255).
REQ-003 SHALL have parameter GUARD, default 4: extra accumulator bits above 2*WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port prod_in  input  2*WIDTH  signed product (multiplier O).
REQ-007 SHALL have port finish_in  input  1  multiplier Finish level; product valid while high.
REQ-008 SHALL have port clear  input  1  synchronous abort/restart of the current sum.
REQ-009 SHALL have port acc_ready  input  1  downstream accepts acc_out.
REQ-010 SHALL have port acc_out  output  2*WIDTH+GUARD  signed accumulated sum.
REQ-011 SHALL have port acc_valid  output  1  acc_out holds a completed NUM_TERMS sum.
REQ-012 SHALL have port term_count  output  8  products accumulated in the current sum.
REQ-013 SHALL have port overflow  output  1  sticky signed-overflow flag for the current sum.
REQ-014 SHALL have port overrun  output  1  sticky flag: product arrived while in DONE.

Function
REQ-015 SHALL capture exactly one product per rising edge of finish_in (high now, low the previous cycle); a level held high SHALL NOT recapture.
REQ-016 SHALL use two states: ACCUM and DONE.
REQ-017 In ACCUM, a capture SHALL add sign-extended prod_in to acc_out and increment term_count, both visible the next cycle.
REQ-018 When a capture makes term_count equal NUM_TERMS, the state SHALL become DONE, with acc_valid high the cycle after that capture.
REQ-019 In DONE, acc_out, term_count and overflow SHALL hold; a capture SHALL be dropped and SHALL set overrun.
REQ-020 The handshake SHALL occur on acc_valid and acc_ready both high; the next cycle SHALL be ACCUM with acc_out=0 and term_count=0.
REQ-021 If a handshake and a finish edge coincide, the product SHALL start the next sum: acc_out=prod_in, term_count=1.
REQ-022 clear SHALL force ACCUM with acc_out=0, term_count=0, overflow=0, overrun=0; it overrides a coincident handshake or capture, and that capture SHALL be discarded.
REQ-023 overflow SHALL set when an addition's true signed result lies outside the acc_out range; it SHALL be cleared by handshake, clear or reset.
REQ-024 If NUM_TERMS=1, every capture SHALL go directly to DONE.

Reset
REQ-025 reset low SHALL force ACCUM, acc_out=0, term_count=0, acc_valid=0, overflow=0, overrun=0.
REQ-026 The finish edge-detect history SHALL reset to 1, so a finish_in held high across reset release SHALL NOT count.
REQ-027 reset mid-sum SHALL discard the partial sum with no acc_valid pulse.

Configuration
REQ-028 Macro BOOTH_ACC_SATURATE_EN defined: an overflowing addition SHALL clamp acc_out to the signed max/min, and overflow SHALL still set.
REQ-029 Macro undefined: acc_out SHALL wrap modulo 2^(2*WIDTH+GUARD), and overflow SHALL still set.

Structure
REQ-030 Shared package booth_pkg SHALL hold the ACCUM/DONE state typedef and the term_count width constant (8).
REQ-031 The finish_in rising-edge detector SHALL be sub-module booth_finish_edge (ports clk, reset, level_in, rise_out).

Verification (WIDTH=4, GUARD=2, NUM_TERMS=4 unless stated)
REQ-032 Four finish pulses with prod_in=18 -> acc_valid=1 one cycle after the 4th edge, acc_out=72, term_count=4.
REQ-033 Products -56, 64, -8, 8 -> acc_out=8; acc_ready held low for 5 cycles -> acc_out stays 8 and acc_valid stays 1; with a 5th pulse -> overrun=1.
REQ-034 finish_in held high for 10 cycles -> term_count=1; finish_in high at reset release -> term_count=0.
REQ-035 Handshake coincident with a finish edge, prod_in=5 -> next cycle acc_valid=0, acc_out=5, term_count=1.
REQ-036 GUARD=0, products 64, 64 -> wrap build: acc_out=-128 and overflow=1; BOOTH_ACC_SATURATE_EN build: acc_out=127 and overflow=1.
REQ-037 clear asserted after 2 captures, coincident with a 3rd edge -> acc_out=0, term_count=0, and flags cleared.
